// File: rtl/fpu_cmp_sched.sv
// fpu_cmp_sched: round-robin scheduler sharing one bfloat16 comparator
// (EQ/LT/LE) between NUM_REQ requesters. The result is registered once and
// tagged with the requester ID. The response drains over a valid/ready channel.
// Optional feature macro: FPU_CMP_NAN_EN (NaN operands report err, rd=0).
module fpu_cmp_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*16-1:0]   req_rs1_i,
  input  logic [NUM_REQ*16-1:0]   req_rs2_i,
  input  logic [NUM_REQ*2-1:0]    req_mode_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IDW-1:0]          rsp_id_o,
  output logic                    rsp_rd_o,
  output logic                    rsp_err_o
);

  localparam int unsigned OPW   = 16;
  localparam int unsigned MODEW = 2;
  localparam int unsigned MAGW  = 15;
  localparam int unsigned EXPW  = 8;
  localparam int unsigned MANW  = 7;

  typedef enum logic [MODEW-1:0] {
    MODE_LE  = 2'b00,
    MODE_LT  = 2'b01,
    MODE_EQ  = 2'b10,
    MODE_ILL = 2'b11
  } cmp_mode_e;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           rd;
    logic           err;
  } rsp_t;

  logic [OPW-1:0]   rs1_a  [NUM_REQ];
  logic [OPW-1:0]   rs2_a  [NUM_REQ];
  logic [MODEW-1:0] mode_a [NUM_REQ];

  logic           can_accept;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand_idx;
  logic [IDW-1:0] ptr_q;

  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  cmp_mode_e      sel_mode;
  logic [1:0]     sgn;
  logic           mag_lt;
  logic           bits_eq;
  logic           cmp_rd;
  logic           cmp_err;

  rsp_t           rsp_q;
  logic           rsp_valid_q;

  // Unpack the flat per-requester operand buses into arrays
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rs1_a[i]  = req_rs1_i[i*OPW +: OPW];
    assign rs2_a[i]  = req_rs2_i[i*OPW +: OPW];
    assign mode_a[i] = req_mode_i[i*MODEW +: MODEW];
  end

  // Round-robin arbiter: first valid requester at or after the pointer
  always_comb begin
    can_accept = rst_ni && (!rsp_valid_q || rsp_ready_i);
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    cand_idx   = '0;
    if (can_accept) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand_idx = IDW'((32'(ptr_q) + k) % NUM_REQ);
        if (!gnt_found && req_valid_i[cand_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
  end

  // One-hot accept on the granted requester
  always_comb begin
    req_ready_o = '0;
    if (gnt_found) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Shared comparator on the granted requester's operands
  always_comb begin
    op_a     = rs1_a[gnt_idx];
    op_b     = rs2_a[gnt_idx];
    sel_mode = cmp_mode_e'(mode_a[gnt_idx]);
    sgn      = {op_a[OPW-1], op_b[OPW-1]};
    bits_eq  = (op_a == op_b);
    mag_lt   = (op_a[MAGW-1:0] < op_b[MAGW-1:0]);
    cmp_rd   = 1'b0;
    cmp_err  = 1'b0;
    case (sel_mode)
      MODE_EQ: cmp_rd = bits_eq;
      MODE_LT: begin
        case (sgn)
          2'b00:   cmp_rd = mag_lt;
          2'b01:   cmp_rd = 1'b0;
          2'b10:   cmp_rd = 1'b1;
          default: cmp_rd = !(mag_lt || bits_eq);
        endcase
      end
      MODE_LE: begin
        case (sgn)
          2'b00:   cmp_rd = mag_lt || bits_eq;
          2'b01:   cmp_rd = 1'b0;
          2'b10:   cmp_rd = 1'b1;
          default: cmp_rd = !mag_lt;
        endcase
      end
      default: begin
        cmp_rd  = 1'b0;
        cmp_err = 1'b1;
      end
    endcase
`ifdef FPU_CMP_NAN_EN
    if ((sel_mode != MODE_ILL) &&
        (((op_a[MAGW-1:MANW] == {EXPW{1'b1}}) && (op_a[MANW-1:0] != '0)) ||
         ((op_b[MAGW-1:MANW] == {EXPW{1'b1}}) && (op_b[MANW-1:0] != '0)))) begin
      cmp_rd  = 1'b0;
      cmp_err = 1'b1;
    end
`endif
  end

  // Round-robin pointer: moves past the granted requester, held otherwise
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_found) begin
      if (gnt_idx == IDW'(NUM_REQ - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= gnt_idx + IDW'(1);
      end
    end
  end

  // Output stage: load on grant (replacing a draining result), clear on drain
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else if (gnt_found) begin
      rsp_valid_q <= 1'b1;
      rsp_q.id    <= gnt_idx;
      rsp_q.rd    <= cmp_rd;
      rsp_q.err   <= cmp_err;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_q.id;
  assign rsp_rd_o    = rsp_q.rd;
  assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_fpu_cmp_sched.sv
// Testbench for fpu_cmp_sched: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from an ordering-based reference model.
module tb_fpu_cmp_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*16-1:0]  req_rs1;
  logic [N*16-1:0]  req_rs2;
  logic [N*2-1:0]   req_mode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_rd;
  logic             rsp_err;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           rd;
    logic           err;
  } exp_t;

  exp_t         sbq[$];
  int           tests = 0;
  int           fails = 0;
  int           m_ptr = 0;
  bit           m_valid = 1'b0;
  logic [N-1:0] granted = '0;
  logic [15:0]  ra;
  logic [15:0]  rb;

  always #5 clk = ~clk;

  fpu_cmp_sched #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .req_mode_i  (req_mode),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_rd_o    (rsp_rd),
    .rsp_err_o   (rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference compare: map each bf16 onto an integer line where -0 sits just below +0
  function automatic logic [1:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] mode);
    int  ka;
    int  kb;
    bit  rd;
    bit  err;
    ka = int'({17'd0, a[14:0]});
    kb = int'({17'd0, b[14:0]});
    if (a[15]) ka = -ka - 1;
    if (b[15]) kb = -kb - 1;
    rd  = 1'b0;
    err = 1'b0;
    case (mode)
      2'b10:   rd = (a == b);
      2'b01:   rd = (ka < kb);
      2'b00:   rd = (ka <= kb);
      default: err = 1'b1;
    endcase
`ifdef FPU_CMP_NAN_EN
    if (mode != 2'b11 && ((a[14:7] == 8'hFF && a[6:0] != 7'd0) ||
                          (b[14:7] == 8'hFF && b[6:0] != 7'd0))) begin
      rd  = 1'b0;
      err = 1'b1;
    end
`endif
    return {rd, err};
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return {1'($urandom_range(0, 1)), 8'hFF, 7'($urandom_range(0, 127))};
      3:       return {1'($urandom_range(0, 1)), 15'($urandom_range(0, 3))};
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference model: predict the grant, check it, push the expected response
  always @(negedge clk) begin : p_model
    logic [N-1:0] exp_rdy;
    int           g;
    int           p;
    exp_t         e;
    exp_rdy = '0;
    g       = -1;
    if (rst_n !== 1'b1) begin
      m_valid = 1'b0;
      m_ptr   = 0;
    end else begin
      if (!m_valid || rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          p = (m_ptr + k) % N;
          if (g < 0 && req_valid[p]) g = p;
        end
      end
      if (g >= 0) begin
        exp_rdy[g]     = 1'b1;
        e.id           = IDW'(g);
        {e.rd, e.err}  = ref_cmp(req_rs1[g*16 +: 16], req_rs2[g*16 +: 16], req_mode[g*2 +: 2]);
        sbq.push_back(e);
        m_ptr   = (g + 1) % N;
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    granted = exp_rdy;
  end

  // Monitor: compare the presented response against the scoreboard head
  always @(negedge clk) begin : p_mon
    #1;
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      chk("rsp_pending", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        chk("rsp_id",  32'(rsp_id),  32'(sbq[0].id));
        chk("rsp_rd",  32'(rsp_rd),  32'(sbq[0].rd));
        chk("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] m);
    req_rs1[p*16 +: 16] = a;
    req_rs2[p*16 +: 16] = b;
    req_mode[p*2 +: 2]  = m;
    req_valid[p]        = 1'b1;
  endtask

  task automatic single(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, input logic rd, input logic err);
    step();
    req_valid = '0;
    set_port(0, a, b, m);
    @(negedge clk);
    chk({name, "_gnt"}, 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_id"},    32'(rsp_id),    32'd0);
    chk({name, "_rd"},    32'(rsp_rd),    32'(rd));
    chk({name, "_err"},   32'(rsp_err),   32'(err));
  endtask

  initial begin
    // Reset held with every requester asking
    rst_n     = 1'b0;
    req_valid = '1;
    req_rs1   = {N{16'h3F80}};
    req_rs2   = {N{16'h4000}};
    req_mode  = {N{2'b01}};
    rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    step();
    rst_n = 1'b1;

    // Round-robin with all requesters continuously valid
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k > 0) begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
      end
    end
    step();
    req_valid = '0;
    repeat (2) step();

    // Comparator semantics on port 0
    single("lt_pos",    16'h3F80, 16'h4000, 2'b01, 1'b1, 1'b0);
    single("lt_neg",    16'hBF80, 16'hC000, 2'b01, 1'b0, 1'b0);
    single("le_eqneg",  16'hC000, 16'hC000, 2'b00, 1'b1, 1'b0);
    single("eq_zeros",  16'h0000, 16'h8000, 2'b10, 1'b0, 1'b0);
    single("illegal",   16'h3F80, 16'h3F80, 2'b11, 1'b0, 1'b1);
    single("lt_nzpz",   16'h8000, 16'h0000, 2'b01, 1'b1, 1'b0);
    single("le_nznz",   16'h8000, 16'h8000, 2'b00, 1'b1, 1'b0);
    single("lt_rev",    16'h4000, 16'h3F80, 2'b01, 1'b0, 1'b0);
`ifdef FPU_CMP_NAN_EN
    single("nan_eq",    16'h7FC1, 16'h7FC1, 2'b10, 1'b0, 1'b1);
`else
    single("nan_eq",    16'h7FC1, 16'h7FC1, 2'b10, 1'b1, 1'b0);
`endif

    // Backpressure: response held, then drain and reload in one cycle
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    set_port(2, 16'h3F80, 16'h4000, 2'b01);
    @(negedge clk);
    chk("bp_gnt0", 32'(req_ready), 32'h4);
    step();
    set_port(2, 16'h4000, 16'h3F80, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id",    32'(rsp_id),    32'd2);
      chk("bp_rd",    32'(rsp_rd),    32'd1);
      if (i < 2) step();
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_regrant", 32'(req_ready), 32'h4);
    chk("bp_old_rd",  32'(rsp_rd),    32'd1);
    step();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", 32'(rsp_valid), 32'd1);
    chk("bp_new_id",    32'(rsp_id),    32'd2);
    chk("bp_new_rd",    32'(rsp_rd),    32'd0);

    // Pointer wrap and skip
    step();
    req_valid = '0;
    set_port(3, 16'h1234, 16'h1234, 2'b10);
    @(negedge clk);
    chk("wrap_g3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    set_port(1, 16'hC000, 16'h4000, 2'b00);
    @(negedge clk);
    chk("skip_g1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    set_port(1, 16'h0001, 16'h0002, 2'b01);
    set_port(2, 16'h8001, 16'h8002, 2'b01);
    @(negedge clk);
    chk("ptr_g2_first", 32'(req_ready), 32'h4);
    step();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("ptr_g1_next", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    repeat (2) step();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int p = 0; p < N; p++) begin
        if (!req_valid[p] || granted[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            ra = rand_op();
            case ($urandom_range(0, 3))
              0:       rb = ra;
              1:       rb = ra ^ 16'h8000;
              default: rb = rand_op();
            endcase
            set_port(p, ra, rb, 2'($urandom_range(0, 3)));
          end else begin
            req_valid[p] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
